// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: operand/control bundle between the ID/EX stage and the mult/div unit.
// Latency: none (wires only). Backpressure: the unit's busy output is the only stall signal.
// master = issuing stage (drives flush/start/op/operands/MTHI/MTLO), slave = mult/div unit.
interface ex_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rdat1;
  logic [WIDTH-1:0] rdat2;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             busy;
  logic             done;

  modport master (
    output flush, start, op, rdat1, rdat2, hi_we, lo_we, wdat,
    input  hi_o, lo_o, busy, done
  );

  modport slave (
    input  flush, start, op, rdat1, rdat2, hi_we, lo_we, wdat,
    output hi_o, lo_o, busy, done
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO (MTHI/MTLO/MFHI/MFLO).
// Latency: WIDTH cycles busy per op (1 cycle for divide-by-zero), done pulses the cycle after.
// Backpressure: busy stalls dependents; start while busy is ignored; flush aborts without touching HI/LO.
// Ports: CLK, RST (sync active-high), mdif (slave modport: flush/start/op/rdat1/rdat2/hi_we/lo_we/wdat
//        in; hi_o/lo_o/busy/done out).
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic            CLK,
  input logic            RST,
  ex_muldiv_unit_if.slave mdif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi_r, lo_r;
  // acc_hi/acc_lo: running partial product (mul) or remainder/quotient pair (div)
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [WIDTH-1:0] mag_b;
  logic             neg_res;   // product / quotient must be negated
  logic             neg_rem;   // dividend was negative (remainder sign, div-by-zero restore)
  logic             dz;        // divide by zero latched at start
  logic             done_r;

  // Operand magnitudes: op[0]=1 selects the unsigned variants
  logic             is_signed, a_neg, b_neg, start_ok, last;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;

  assign is_signed = ~mdif.op[0];
  assign a_neg     = is_signed & mdif.rdat1[WIDTH-1];
  assign b_neg     = is_signed & mdif.rdat2[WIDTH-1];
  assign mag_a_in  = a_neg ? -mdif.rdat1 : mdif.rdat1;
  assign mag_b_in  = b_neg ? -mdif.rdat2 : mdif.rdat2;
  assign start_ok  = (state == IDLE) & mdif.start & ~mdif.flush;
  assign last      = (cnt == CNT_W'(WIDTH - 1));

  // One shift-add step: add multiplicand when the current multiplier LSB is set,
  // then shift the {carry, acc_hi, acc_lo} chain right by one.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_n, mul_lo_n;
  logic [2*WIDTH-1:0] prod, prod_fin;

  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
  assign mul_hi_n = mul_sum[WIDTH:1];
  assign mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};
  assign prod     = {mul_hi_n, mul_lo_n};
  assign prod_fin = neg_res ? -prod : prod;

  // One restoring-division step: bring the next dividend bit into the remainder,
  // trial-subtract the divisor and keep the difference if it did not go negative.
  // The remainder is always < divisor, so WIDTH+1 bits hold the trial difference.
  logic [WIDTH:0]   rem_sh, diff;
  logic             ge;
  logic [WIDTH-1:0] div_hi_n, div_lo_n, quo_fin, rem_fin;

  assign rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, mag_b};
  assign ge       = ~diff[WIDTH];
  assign div_hi_n = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign div_lo_n = {acc_lo[WIDTH-2:0], ge};
  assign quo_fin  = neg_res ? -div_lo_n : div_lo_n;
  assign rem_fin  = neg_rem ? -div_hi_n : div_hi_n;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; flush overrides everything except reset
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_n = mdif.op[1] ? DIV : MUL;
        end
      end
      MUL: begin
        if (last) begin
          state_n = IDLE;
        end
      end
      DIV: begin
        if (dz || last) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (mdif.flush) begin
      state_n = IDLE;
    end
  end

  // Datapath and HI/LO
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt     <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      mag_b   <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (!mdif.flush) begin
        case (state)
          IDLE: begin
            if (mdif.start) begin
              cnt     <= '0;
              acc_hi  <= '0;
              acc_lo  <= mag_a_in;
              mag_b   <= mag_b_in;
              neg_res <= a_neg ^ b_neg;
              neg_rem <= a_neg;
              dz      <= mdif.op[1] & (mdif.rdat2 == '0);
            end else begin
              if (mdif.hi_we) hi_r <= mdif.wdat;
              if (mdif.lo_we) lo_r <= mdif.wdat;
            end
          end
          MUL: begin
            acc_hi <= mul_hi_n;
            acc_lo <= mul_lo_n;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
              hi_r   <= prod_fin[2*WIDTH-1:WIDTH];
              lo_r   <= prod_fin[WIDTH-1:0];
              done_r <= 1'b1;
            end
          end
          DIV: begin
            if (dz) begin
              // Re-apply the dividend sign to recover the original rdat1
              hi_r   <= neg_rem ? -acc_lo : acc_lo;
              lo_r   <= '1;
              done_r <= 1'b1;
            end else begin
              acc_hi <= div_hi_n;
              acc_lo <= div_lo_n;
              cnt    <= cnt + CNT_W'(1);
              if (last) begin
                hi_r   <= rem_fin;
                lo_r   <= quo_fin;
                done_r <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mdif.hi_o = hi_r;
  assign mdif.lo_o = lo_r;
  assign mdif.busy = (state != IDLE);
  assign mdif.done = done_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed + random checks of ex_muldiv_unit against an arithmetic reference.
// Latency: checks busy length (32, or 1 for divide by zero) and the done pulse after it.
// Backpressure: exercises flush/reset aborts and start/write collisions.
module tb_ex_muldiv_unit;

  logic CLK;
  logic RST;
  int   n_chk;
  int   n_fail;
  logic [31:0] mhi, mlo;   // reference HI/LO

  ex_muldiv_unit_if #(.WIDTH(32)) mdif ();

  ex_muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .mdif (mdif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {HI, LO} from plain arithmetic on the architectural definitions
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      2'd0: begin p = sa * sb; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; end
      default: begin
        if (b == 32'd0) begin
          p = {a, 32'hFFFF_FFFF};
        end else if (op == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else begin
          p = {a % b, a / b};
        end
      end
    endcase
    return p;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke, input string tag);
    logic [63:0] exp;
    int n;
    bit early_done;
    exp = model(op, a, b);
    mdif.op    = op;
    mdif.rdat1 = a;
    mdif.rdat2 = b;
    mdif.start = 1'b1;
    tick();
    mdif.start = 1'b0;
    mdif.hi_we = 1'b0;
    mdif.lo_we = 1'b0;
    n = 0;
    early_done = 1'b0;
    while (mdif.busy && n < 100) begin
      if (mdif.done) early_done = 1'b1;
      n++;
      if (poke && n == 5) begin
        mdif.start = 1'b1;
        mdif.op    = 2'd1;
        mdif.rdat1 = 32'h0000_1234;
        mdif.rdat2 = 32'h0000_0010;
      end
      tick();
      mdif.start = 1'b0;
    end
    chk({tag, "_busy_len"}, 64'(n), (op[1] && b == 32'd0) ? 64'd1 : 64'd32);
    chk({tag, "_done_in_busy"}, 64'(early_done), 64'd0);
    chk({tag, "_done"}, 64'(mdif.done), 64'd1);
    chk({tag, "_hi"}, 64'(mdif.hi_o), 64'(exp[63:32]));
    chk({tag, "_lo"}, 64'(mdif.lo_o), 64'(exp[31:0]));
    mhi = exp[63:32];
    mlo = exp[31:0];
    tick();
    chk({tag, "_done_drop"}, 64'(mdif.done), 64'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    mhi    = '0;
    mlo    = '0;
    RST        = 1'b1;
    mdif.flush = 1'b0;
    mdif.start = 1'b0;
    mdif.op    = 2'd0;
    mdif.rdat1 = '0;
    mdif.rdat2 = '0;
    mdif.hi_we = 1'b0;
    mdif.lo_we = 1'b0;
    mdif.wdat  = '0;
    tick(); tick(); tick();
    RST = 1'b0;
    chk("rst_hi", 64'(mdif.hi_o), 64'd0);
    chk("rst_lo", 64'(mdif.lo_o), 64'd0);
    chk("rst_busy", 64'(mdif.busy), 64'd0);
    chk("rst_done", 64'(mdif.done), 64'd0);

    // Directed arithmetic cases
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    chk("multu_max_hi_const", 64'(mhi), 64'h0000_0000_FFFF_FFFE);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, "mult_neg");
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
    run_op(2'd3, 32'd100, 32'd7, 1'b0, "divu");
    run_op(2'd3, 32'h64, 32'd0, 1'b0, "divu_zero");
    run_op(2'd2, 32'hFFFF_FF9C, 32'd0, 1'b0, "div_zero_neg");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");

    // Preload via MTHI/MTLO
    mdif.hi_we = 1'b1; mdif.wdat = 32'hAAAA_0000; tick();
    mdif.hi_we = 1'b0; mdif.lo_we = 1'b1; mdif.wdat = 32'h0000_5555; tick();
    mdif.lo_we = 1'b0;
    chk("mthi", 64'(mdif.hi_o), 64'h0000_0000_AAAA_0000);
    chk("mtlo", 64'(mdif.lo_o), 64'h0000_0000_0000_5555);

    // Flush on 10th busy cycle
    mdif.op = 2'd1; mdif.rdat1 = 32'd3; mdif.rdat2 = 32'd4; mdif.start = 1'b1;
    tick();
    mdif.start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("flush_pre_busy", 64'(mdif.busy), 64'd1);
    mdif.flush = 1'b1;
    tick();
    mdif.flush = 1'b0;
    chk("flush_busy", 64'(mdif.busy), 64'd0);
    chk("flush_done", 64'(mdif.done), 64'd0);
    chk("flush_hi", 64'(mdif.hi_o), 64'h0000_0000_AAAA_0000);
    chk("flush_lo", 64'(mdif.lo_o), 64'h0000_0000_0000_5555);
    for (int i = 0; i < 35; i++) tick();
    chk("flush_late_hi", 64'(mdif.hi_o), 64'h0000_0000_AAAA_0000);
    chk("flush_late_done", 64'(mdif.done), 64'd0);

    // Reset mid-operation
    mdif.start = 1'b1;
    tick();
    mdif.start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rstab_busy", 64'(mdif.busy), 64'd0);
    chk("rstab_hi", 64'(mdif.hi_o), 64'd0);
    chk("rstab_lo", 64'(mdif.lo_o), 64'd0);
    tick();
    chk("rstab_done", 64'(mdif.done), 64'd0);

    // start with hi_we: op wins, write dropped
    mdif.hi_we = 1'b1; mdif.wdat = 32'hDEAD_BEEF;
    run_op(2'd3, 32'd100, 32'd7, 1'b0, "start_vs_we");
    // start while busy ignored
    run_op(2'd1, 32'd3, 32'd4, 1'b1, "start_in_busy");
    // start + flush in IDLE: nothing
    mdif.op = 2'd1; mdif.rdat1 = 32'd9; mdif.rdat2 = 32'd9;
    mdif.start = 1'b1; mdif.flush = 1'b1; mdif.hi_we = 1'b1; mdif.lo_we = 1'b1;
    mdif.wdat = 32'h0000_FFFF;
    tick();
    mdif.start = 1'b0; mdif.flush = 1'b0; mdif.hi_we = 1'b0; mdif.lo_we = 1'b0;
    chk("sf_busy", 64'(mdif.busy), 64'd0);
    chk("sf_hi", 64'(mdif.hi_o), 64'd0);
    chk("sf_lo", 64'(mdif.lo_o), 64'd12);
    tick();
    chk("sf_busy2", 64'(mdif.busy), 64'd0);
    chk("sf_done", 64'(mdif.done), 64'd0);

    // Random ops and MTHI/MTLO
    for (int k = 0; k < 30; k++) begin
      int sel;
      logic [31:0] a, b;
      sel = int'($urandom_range(0, 4));
      if (sel == 0) begin
        mdif.hi_we = 1'($urandom_range(0, 1));
        mdif.lo_we = 1'($urandom_range(0, 1));
        mdif.wdat  = $urandom;
        if (mdif.hi_we) mhi = mdif.wdat;
        if (mdif.lo_we) mlo = mdif.wdat;
        tick();
        mdif.hi_we = 1'b0;
        mdif.lo_we = 1'b0;
        chk("rnd_mt_hi", 64'(mdif.hi_o), 64'(mhi));
        chk("rnd_mt_lo", 64'(mdif.lo_o), 64'(mlo));
      end else begin
        a = $urandom;
        b = $urandom;
        case ($urandom_range(0, 5))
          0: b = 32'd0;
          1: b = $urandom_range(1, 15);
          2: a = $urandom_range(0, 1000);
          default: ;
        endcase
        run_op(2'($urandom_range(0, 3)), a, b, 1'b0, "rnd_op");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
